// File: rtl/ascii_to_ps2_tx.sv
// ascii_to_ps2_tx: ASCII to PS/2 Set-2 keystroke (make, F0, make) device-side transmitter; define PS2_TX_HOST_INHIBIT_EN for host clock-inhibit handling via PS2_CLK_IN.
module ascii_to_ps2_tx #(
   parameter int CLK_HALF   = 2000,
   parameter int GAP_CYCLES = 5000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [7:0] ASCII_Data,
   input  logic       ASCII_Valid,
`ifdef PS2_TX_HOST_INHIBIT_EN
   input  logic       PS2_CLK_IN,
`endif
   output logic       Busy,
   output logic       Done_Sig,
   output logic       Unmapped_Sig,
   output logic       PS2_CLK_OUT,
   output logic       PS2_DAT_OUT
);
   localparam int HW = $clog2(CLK_HALF + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [HW-1:0] HALF_M1 = HW'(CLK_HALF - 1);
   localparam logic [HW-1:0] HALF_M2 = HW'(CLK_HALF > 1 ? CLK_HALF - 2 : 0);
   localparam logic [GW-1:0] GAP_M1 = GW'(GAP_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
   state_t        state_q, state_d;
   logic [7:0]    code_q, code_d;
   logic [1:0]    frame_q, frame_d;
   logic [3:0]    bit_q, bit_d;
   logic          ph_q, ph_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [GW-1:0] gcnt_q, gcnt_d;
   logic          unm_q, unm_d;
   logic          pclk_q, pclk_d;
   logic          pdat_q, pdat_d;
   logic [7:0]    up, scan, tx_byte;
   logic [10:0]   frame_bits;
   logic          mapped, half_end, done_go, line_hi, inhibit;
`ifdef PS2_TX_HOST_INHIBIT_EN
   logic [1:0]    sync_q, sync_d;
   assign sync_d  = {sync_q[0], PS2_CLK_IN};
   assign line_hi = sync_q[1];
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) sync_q <= 2'b11;
      else sync_q <= sync_d;
   end
`else
   assign line_hi = 1'b1;
`endif
   always_comb begin
      up = (ASCII_Data >= 8'h61 && ASCII_Data <= 8'h7A) ? ASCII_Data - 8'h20 : ASCII_Data;
      scan = 8'h00;
      mapped = 1'b1;
      case (up)
         8'h30: scan = 8'h45;
         8'h31: scan = 8'h16;
         8'h32: scan = 8'h1E;
         8'h33: scan = 8'h26;
         8'h34: scan = 8'h25;
         8'h35: scan = 8'h2E;
         8'h36: scan = 8'h36;
         8'h37: scan = 8'h3D;
         8'h38: scan = 8'h3E;
         8'h39: scan = 8'h46;
         8'h41: scan = 8'h1C;
         8'h42: scan = 8'h32;
         8'h43: scan = 8'h21;
         8'h44: scan = 8'h23;
         8'h45: scan = 8'h24;
         8'h46: scan = 8'h2B;
         8'h47: scan = 8'h34;
         8'h48: scan = 8'h33;
         8'h49: scan = 8'h43;
         8'h4A: scan = 8'h3B;
         8'h4B: scan = 8'h42;
         8'h4C: scan = 8'h4B;
         8'h4D: scan = 8'h3A;
         8'h4E: scan = 8'h31;
         8'h4F: scan = 8'h44;
         8'h50: scan = 8'h4D;
         8'h51: scan = 8'h15;
         8'h52: scan = 8'h2D;
         8'h53: scan = 8'h1B;
         8'h54: scan = 8'h2C;
         8'h55: scan = 8'h3C;
         8'h56: scan = 8'h2A;
         8'h57: scan = 8'h1D;
         8'h58: scan = 8'h22;
         8'h59: scan = 8'h35;
         8'h5A: scan = 8'h1A;
         default: mapped = 1'b0;
      endcase
   end
   always_comb begin
      state_d = state_q;
      code_d = code_q;
      frame_d = frame_q;
      bit_d = bit_q;
      ph_d = ph_q;
      hcnt_d = hcnt_q;
      gcnt_d = gcnt_q;
      unm_d = 1'b0;
      half_end = hcnt_q == HALF_M1;
      inhibit = !ph_q && !line_hi && bit_q != 4'd10;
      done_go = frame_q == 2'd2 && bit_q == 4'd10 &&
                (CLK_HALF == 1 ? !ph_q && half_end : ph_q && hcnt_q == HALF_M2);
      case (state_q)
         IDLE: if (ASCII_Valid) begin
            unm_d = !mapped;
            code_d = scan;
            frame_d = 2'd0;
            state_d = mapped ? SEND : IDLE;
         end
         SEND: begin
            hcnt_d = half_end ? '0 : hcnt_q + 1'b1;
            ph_d = ph_q ^ half_end;
            bit_d = bit_q + {3'd0, half_end & ph_q};
            if (inhibit) state_d = GAP;
            else if (done_go) state_d = DONE;
            else if (half_end && ph_q && bit_q == 4'd10) begin
               state_d = GAP;
               frame_d = frame_q + 2'd1;
            end
         end
         GAP: begin
            gcnt_d = line_hi ? gcnt_q + 1'b1 : '0;
            if (line_hi && gcnt_q == GAP_M1) state_d = SEND;
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) begin
         hcnt_d = '0;
         gcnt_d = '0;
         bit_d = 4'd0;
         ph_d = 1'b0;
      end
      // DONE overlaps the stop bit's final low cycle so the keystroke ends exactly on it
      tx_byte = frame_d == 2'd1 ? 8'hF0 : code_d;
      frame_bits = {1'b1, ~^tx_byte, tx_byte, 1'b0};
      pdat_d = state_d == SEND ? frame_bits[bit_d] : 1'b1;
      pclk_d = !(state_d == DONE || (state_d == SEND && ph_d));
   end
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
         code_q <= 8'h00;
         frame_q <= 2'd0;
         bit_q <= 4'd0;
         ph_q <= 1'b0;
         hcnt_q <= '0;
         gcnt_q <= '0;
         unm_q <= 1'b0;
         pclk_q <= 1'b1;
         pdat_q <= 1'b1;
      end else begin
         state_q <= state_d;
         code_q <= code_d;
         frame_q <= frame_d;
         bit_q <= bit_d;
         ph_q <= ph_d;
         hcnt_q <= hcnt_d;
         gcnt_q <= gcnt_d;
         unm_q <= unm_d;
         pclk_q <= pclk_d;
         pdat_q <= pdat_d;
      end
   end
   assign Busy = state_q != IDLE;
   assign Done_Sig = state_q == DONE;
   assign Unmapped_Sig = unm_q;
   assign PS2_CLK_OUT = pclk_q;
   assign PS2_DAT_OUT = pdat_q;
endmodule

// File: doc/ascii_to_ps2_tx.md
Name: ascii_to_ps2_tx

Overview:
Device-side PS/2 keyboard emulator. Takes one ASCII character code, maps it to its Set-2 scancode, and serialises a full keystroke on the PS/2 clock/data lines: make code, then F0 break prefix, then make code again. The block drives the PS/2 clock itself, so an FPGA can stand in for a keyboard toward a host-side PS/2 receiver. Sits between an ASCII source (UART/Modbus payload path) and the PS/2 pins.

Parameters:
CLK_HALF, 2000, system clocks per PS/2 clock half-period (50 MHz gives 12.5 kHz).
GAP_CYCLES, 5000, idle system clocks between consecutive frames of one keystroke; minimum 1.

Ports:
CLK  input  1  system clock
RSTn  input  1  asynchronous active-low reset
ASCII_Data  input  8  character to send
ASCII_Valid  input  1  one-cycle request strobe; sampled only while Busy=0
Busy  output  1  high from acceptance until Done_Sig
Done_Sig  output  1  one-cycle pulse when the keystroke is complete
Unmapped_Sig  output  1  one-cycle pulse when ASCII_Data has no mapping
PS2_CLK_OUT  output  1  PS/2 clock line level (1 = released/high)
PS2_DAT_OUT  output  1  PS/2 data line level (1 = released/high)

Behaviour:
- Clock CLK, asynchronous active-low reset RSTn. Reset values: Busy=0, Done_Sig=0, Unmapped_Sig=0, PS2_CLK_OUT=1, PS2_DAT_OUT=1, FSM=IDLE. Reset asserted mid-frame returns both lines high immediately and discards the keystroke.
- Mapping:
  - '0'-'9' (0x30-0x39) map to 45,16,1E,26,25,2E,36,3D,3E,46.
  - 'A'-'Z' (0x41-0x5A) map to 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A.
  - Lowercase 0x61-0x7A map to the same codes as their uppercase letters.
  - Every other code is unmapped.
- Acceptance: in IDLE, ASCII_Valid=1 latches ASCII_Data.
  - If the code is mapped: next cycle Busy=1 and the FSM enters SEND for frame 0.
  - If the code is unmapped: next cycle Unmapped_Sig=1 for one cycle, Busy stays 0, and the lines do not toggle.
- ASCII_Valid while Busy=1 is ignored and is not queued.
- FSM states: IDLE, SEND, GAP, DONE. Frame index 0..2 selects the transmitted byte: make code, 0xF0, make code.
- SEND frame format: 11 bits. Start bit 0, 8 data bits LSB first, odd parity bit (data plus parity has an odd count of ones), stop bit 1.
- Per-bit timing:
  - Phase H: PS2_DAT_OUT changes to the bit value on the first cycle; PS2_CLK_OUT=1 for CLK_HALF cycles.
  - Phase L: PS2_CLK_OUT=0 for CLK_HALF cycles. Data is stable throughout, so the host samples on the falling edge.
  - One frame therefore lasts 22*CLK_HALF cycles.
- After the stop bit's phase L, PS2_CLK_OUT=1 and PS2_DAT_OUT=1.
  - For frames 0 and 1, the FSM enters GAP: both lines high for GAP_CYCLES, then SEND for the next frame.
  - After frame 2, the FSM enters DONE: Done_Sig=1 for one cycle, Busy falls in that same cycle, then IDLE.
- Total Busy duration: 66*CLK_HALF + 2*GAP_CYCLES cycles, with the DONE cycle as the last cycle.
- Counters: half-period counter sized ceil(log2(CLK_HALF+1)), gap counter sized ceil(log2(GAP_CYCLES+1)), bit counter 4 bits (0..10). All counters clear on state entry.

Optional Feature:
Macro PS2_TX_HOST_INHIBIT_EN.
- Defined: adds input PS2_CLK_IN (1 bit, raw line level), synchronised through 2 flops.
  - If the synchronised line is low during phase H of any bit except the stop bit, the block treats it as host inhibit. It aborts the current frame, releases both lines high, and waits until PS2_CLK_IN has been high for GAP_CYCLES.
  - It then restarts the same frame from the start bit. Busy stays high throughout.
- Undefined: no PS2_CLK_IN port; the line is never monitored, and timing is exactly as above.

Test Plan:
1. CLK_HALF=4, GAP_CYCLES=20, 'A' (0x41) -> three frames decode as 1C, F0, 1C. Frame 0 bits: 0, 0,0,1,1,1,0,0,0, parity 0, stop 1. F0 parity 1. Busy high exactly 304 cycles; Done_Sig in the final Busy cycle.
2. '0' (0x30) -> 45,F0,45; lowercase 'z' (0x7A) -> 1A,F0,1A; 'w' (0x77) -> 1D,F0,1D.
3. 0x20 -> Unmapped_Sig one-cycle pulse one cycle after Valid; Busy=0 and no PS2_CLK_OUT edges for the following 400 cycles.
4. 'B' then 'C' strobed 10 cycles later while Busy -> only 32,F0,32 transmitted; exactly one Done_Sig.
5. RSTn pulled low during frame 1 bit 4 -> PS2_CLK_OUT=1, PS2_DAT_OUT=1 and Busy=0 with no clock edge; a fresh 'A' afterwards transmits normally.
6. With PS2_TX_HOST_INHIBIT_EN: PS2_CLK_IN held low for 50 cycles during frame 1 bit 3 -> frame aborted, lines high, and F0 is resent from the start bit 20 cycles after release. Overall byte sequence is still 1C,F0,1C.
